// File: rtl/contador_m_ud.sv
// Parametrised modulo-M up/down counter with wrap/saturate terminal mode,
// clamped load, midpoint flag, registered wrap pulse and sticky overflow.
module contador_m_ud #(
  parameter int N    = 4,
  parameter int M    = 16,
  parameter int MEIO = M/2 - 1
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         sclr,
  input  logic         ld,
  input  logic         ent,
  input  logic         enp,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         rco,
  output logic         meio,
  output logic         wrap,
  output logic         ovf
);

  if ((M < 2) || (M > (2**N))) begin : g_bad_modulus
    $fatal(1, "contador_m_ud: modulus M=%0d outside 2..2**N (N=%0d)", M, N);
  end

  localparam logic [N-1:0] Q_MAX   = N'(M - 1);
  localparam bit           MEIO_OK = (MEIO >= 0) && (MEIO <= M - 1);
  localparam logic [N-1:0] MEIO_V  = N'(MEIO);

  logic [N-1:0] q_end;
  logic [N-1:0] d_clamp;
  logic         at_end;
  logic         count_en;

  // The terminal value follows the direction sampled this cycle.
  assign q_end    = up ? Q_MAX : '0;
  assign at_end   = (Q == q_end);
  assign count_en = ent & enp;
  assign d_clamp  = (D > Q_MAX) ? Q_MAX : D;

  assign rco  = ent & at_end;
  assign meio = MEIO_OK & (Q == MEIO_V);

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      Q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (!sclr) begin
      Q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (!ld) begin
      Q    <= d_clamp;
      wrap <= 1'b0;
    end else if (count_en) begin
      if (!at_end) begin
        Q    <= up ? (Q + 1'b1) : (Q - 1'b1);
        wrap <= 1'b0;
      end else begin
        // Reaching the terminal value while enabled is an overflow either way.
        ovf <= 1'b1;
        if (sat) begin
          wrap <= 1'b0;
        end else begin
          Q    <= up ? '0 : Q_MAX;
          wrap <= 1'b1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_m_ud.sv
// Bench for contador_m_ud with N=4, M=10, MEIO=4: table-driven vectors plus
// hand-written asynchronous clear sequences, checked through an expected queue.
module tb_contador_m_ud;

  localparam int N = 4;
  localparam int M = 10;
  localparam int W = N + 4;

  logic         clock;
  logic         clr;
  logic         sclr;
  logic         ld;
  logic         ent;
  logic         enp;
  logic         up;
  logic         sat;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         rco;
  logic         meio;
  logic         wrap;
  logic         ovf;

  contador_m_ud #(.N(N), .M(M), .MEIO(4)) dut (
    .clock(clock),
    .clr  (clr),
    .sclr (sclr),
    .ld   (ld),
    .ent  (ent),
    .enp  (enp),
    .up   (up),
    .sat  (sat),
    .D    (d),
    .Q    (q),
    .rco  (rco),
    .meio (meio),
    .wrap (wrap),
    .ovf  (ovf)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         sclr;
    logic         ld;
    logic         ent;
    logic         enp;
    logic         up;
    logic         sat;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         rco;
    logic         meio;
    logic         wrap;
    logic         ovf;
  } vec_t;

  vec_t         tbl[$];
  string        tbl_names[$];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_bad;

  // scoreboard
  task automatic expect_out(input string name, input logic [N-1:0] eq, input logic er,
                            input logic em, input logic ew, input logic eo);
    exp_q.push_back({eq, er, em, ew, eo});
    name_q.push_back(name);
  endtask

  task automatic check_out();
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: DUT output sampled with no expectation queued");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {q, rco, meio, wrap, ovf};
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got Q=%0d rco=%b meio=%b wrap=%b ovf=%b, want Q=%0d rco=%b meio=%b wrap=%b ovf=%b",
                 nm, a[W-1:4], a[3], a[2], a[1], a[0], e[W-1:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  // driver
  task automatic drive(input logic s_sclr, input logic s_ld, input logic s_ent, input logic s_enp,
                       input logic s_up, input logic s_sat, input logic [N-1:0] s_d);
    sclr = s_sclr; ld = s_ld; ent = s_ent; enp = s_enp; up = s_up; sat = s_sat; d = s_d;
  endtask

  task automatic add(input string name, input logic s_sclr, input logic s_ld, input logic s_ent,
                     input logic s_enp, input logic s_up, input logic s_sat, input logic [N-1:0] s_d,
                     input logic [N-1:0] eq, input logic er, input logic em, input logic ew,
                     input logic eo);
    vec_t v;
    v.sclr = s_sclr; v.ld = s_ld; v.ent = s_ent; v.enp = s_enp; v.up = s_up; v.sat = s_sat;
    v.d = s_d; v.q = eq; v.rco = er; v.meio = em; v.wrap = ew; v.ovf = eo;
    tbl.push_back(v);
    tbl_names.push_back(name);
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clock);
    drive(v.sclr, v.ld, v.ent, v.enp, v.up, v.sat, v.d);
    expect_out(name, v.q, v.rco, v.meio, v.wrap, v.ovf);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tbl_names[i]);
    tbl.delete();
    tbl_names.delete();
  endtask

  // Pulses clr between edges and checks the outputs clear before the next edge.
  task automatic clr_pulse(input string name);
    #2;
    clr = 1'b0;
    #1;
    expect_out(name, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
  endtask

  initial begin
    logic [N-1:0] rd;
    logic [N-1:0] rq;
    n_cmp = 0;
    n_bad = 0;
    clr = 1'b0;
    drive(1, 1, 0, 0, 1, 0, 4'd0);
    repeat (3) @(posedge clock);
    #1;
    expect_out("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clock);
    clr = 1'b1;

    // up, wrap mode: 0 -> 9 -> 0 -> 1, then on to 6
    for (int i = 1; i <= 9; i++)
      add("up_count", 1, 1, 1, 1, 1, 0, 4'd0, 4'(i), (i == 9), (i == 4), 1'b0, 1'b0);
    add("up_wrap_9_to_0", 1, 1, 1, 1, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++)
      add("up_after_wrap", 1, 1, 1, 1, 1, 0, 4'd0, 4'(i), 1'b0, (i == 4), 1'b0, 1'b1);
    run_table();

    // asynchronous clear mid-count at Q=6, held across an enabled edge
    clr_pulse("clr_async_at_6");
    @(posedge clock);
    #1;
    expect_out("clr_held_over_edge", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clock);
    clr = 1'b1;
    expect_out("count_after_clr_release", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_out();

    // down, saturate from 2, then down-wrap 0 -> 9
    add("load_2_over_count", 1, 0, 1, 1, 0, 1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    add("down_sat_1", 1, 1, 1, 1, 0, 1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    add("down_sat_0", 1, 1, 1, 1, 0, 1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add("down_sat_hold", 1, 1, 1, 1, 0, 1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    add("down_sat_hold2", 1, 1, 1, 1, 0, 1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    add("down_wrap_0_to_9", 1, 1, 1, 1, 0, 0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    add("down_after_wrap", 1, 1, 1, 1, 0, 0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    // loads, clamping and sclr priority
    add("load_13_clamp", 1, 0, 0, 0, 1, 0, 4'd13, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    add("load_3", 1, 0, 0, 0, 1, 0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    add("sclr_over_load", 0, 0, 0, 0, 1, 0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("load_10_clamp", 1, 0, 0, 0, 1, 0, 4'd10, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("load_9_exact", 1, 0, 0, 0, 1, 0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("load_4_meio", 1, 0, 0, 0, 1, 0, 4'd4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    run_table();

    // random loads: clamp to 9, meio only at 4
    for (int i = 0; i < 10; i++) begin
      rd = 4'($urandom_range(0, 15));
      rq = (rd > 4'd9) ? 4'd9 : rd;
      add("load_random", 1, 0, 0, 0, 1, 0, rd, rq, 1'b0, (rq == 4'd4), 1'b0, 1'b0);
    end
    run_table();

    // rco gating at the terminal value, then sticky ovf
    add("load_9", 1, 0, 0, 0, 1, 0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("enp0_hold_rco", 1, 1, 1, 0, 1, 0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    add("ent0_rco_low", 1, 1, 0, 1, 1, 0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("down_at_9_rco_low", 1, 1, 1, 0, 0, 0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("up_sat_at_9", 1, 1, 1, 1, 1, 1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    add("load_5_keeps_ovf", 1, 0, 1, 1, 1, 0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    add("sclr_clears_ovf", 0, 0, 1, 1, 1, 0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("reload_9", 1, 0, 0, 0, 1, 0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    add("wrap_before_clr", 1, 1, 1, 1, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_table();

    // asynchronous clear while wrap and ovf are both high
    clr_pulse("clr_async_after_wrap");
    @(negedge clock);
    clr = 1'b1;
    drive(1, 1, 0, 0, 1, 0, 4'd0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
